// File: rtl/tx_len_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// tx_len_pattern_gen_pkg
//   Shared definitions for the length-driven pattern generator:
//   - pattern mode codes (mode byte, low two bits)
//   - top-level FSM state encoding
//   - LFSR seed and single-step function
//   - command frame length (1 mode byte + 4 length bytes)
// -----------------------------------------------------------------------------
package tx_len_pattern_gen_pkg;

    // Mode 3 is reserved and falls through to the incrementing pattern.
    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;

    typedef enum logic {
        S_CMD  = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [7:0]  LFSR_SEED = 8'h01;
    localparam int unsigned CMD_BYTES = 5;

    // Fibonacci LFSR8: shift left, feedback taps 7,5,4,3 enter at bit 0.
    function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/tx_len_pattern_gen_pattern_word_gen.sv
// -----------------------------------------------------------------------------
// tx_len_pattern_gen_pattern_word_gen
//   Combinational unroll of OB pattern bytes starting from a given stream
//   position. Lane 0 holds the earliest byte. The caller masks unused lanes
//   of a final partial word.
// Ports
//   mode       in   2      pattern mode (MODE_INC / MODE_CONST / MODE_LFSR)
//   idx        in   8      stream byte index of lane 0, modulo 256
//   lfsr       in   8      LFSR state that produces lane 0
//   word       out  8*OB   OB pattern bytes
//   idx_next   out  8      index of the byte after the last lane
//   lfsr_next  out  8      LFSR state after OB steps
// -----------------------------------------------------------------------------
module tx_len_pattern_gen_pattern_word_gen
    import tx_len_pattern_gen_pkg::*;
#(
    parameter int OB = 4
) (
    input  logic [1:0]      mode,
    input  logic [7:0]      idx,
    input  logic [7:0]      lfsr,
    output logic [8*OB-1:0] word,
    output logic [7:0]      idx_next,
    output logic [7:0]      lfsr_next
);

    always_comb begin
        logic [7:0] idx_v;
        logic [7:0] lfsr_v;
        // NOTE: blocking assignments here chain the per-lane index/LFSR
        // updates within one evaluation; each lane sees the previous lane's value.
        idx_v  = idx;
        lfsr_v = lfsr;
        word   = '0;
        for (int b = 0; b < OB; b++) begin
            case (mode)
                MODE_CONST: word[8*b +: 8] = 8'hFF;
                MODE_LFSR:  word[8*b +: 8] = lfsr_v;
                default:    word[8*b +: 8] = idx_v;
            endcase
            idx_v  = idx_v + 8'd1;
            lfsr_v = lfsr8_step(lfsr_v);
        end
        idx_next  = idx_v;
        lfsr_next = lfsr_v;
    end

endmodule

// File: rtl/tx_len_pattern_gen.sv
// -----------------------------------------------------------------------------
// tx_len_pattern_gen
//   Receives a 5-byte command {mode, len[7:0], len[15:8], len[23:16],
//   len[31:24]} on an 8-bit AXI-stream and emits exactly len pattern bytes
//   on an OB = 2^OW_EW byte AXI-stream with tkeep/tlast.
//   Optional feature macro: TX_LEN_GEN_CMD_TIMEOUT_EN -- discards a partial
//   command after TIMEOUT_CYCLES idle cycles to realign command framing.
// Ports
//   clk       in   1      clock
//   rst       in   1      asynchronous reset, active-high
//   i_tready  out  1      command byte accept (high in S_CMD)
//   i_tvalid  in   1      command byte valid
//   i_tdata   in   8      command byte
//   o_tready  in   1      downstream ready
//   o_tvalid  out  1      output word valid
//   o_tdata   out  8*OB   output word, stream byte order from lane 0 up
//   o_tkeep   out  OB     byte enables
//   o_tlast   out  1      final word of the burst
//   busy      out  1      high in S_SEND
// -----------------------------------------------------------------------------
module tx_len_pattern_gen
    import tx_len_pattern_gen_pkg::*;
#(
    parameter int OW_EW          = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      i_tready,
    input  logic                      i_tvalid,
    input  logic [7:0]                i_tdata,
    input  logic                      o_tready,
    output logic                      o_tvalid,
    output logic [8*(1<<OW_EW)-1:0]   o_tdata,
    output logic [(1<<OW_EW)-1:0]     o_tkeep,
    output logic                      o_tlast,
    output logic                      busy
);

    localparam int         OB       = 1 << OW_EW;
    localparam logic [2:0] CMD_LAST = 3'(CMD_BYTES - 1);

    if (OW_EW < 0 || OW_EW > 4) begin : g_bad_ow_ew
        $error("OW_EW must be in 0..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [23:0]      len_lo_q, len_lo_d;
    logic [31:0]      remaining_q, remaining_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             o_tvalid_q, o_tvalid_d;
    logic [8*OB-1:0]  o_tdata_q, o_tdata_d;
    logic [OB-1:0]    o_tkeep_q, o_tkeep_d;
    logic             o_tlast_q, o_tlast_d;

`ifdef TX_LEN_GEN_CMD_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Pattern source: idx_q/lfsr_q sit at 0/seed whenever in S_CMD, so the
    // first word of every command starts the pattern afresh.
    logic [8*OB-1:0] gen_word;
    logic [7:0]      gen_idx_next;
    logic [7:0]      gen_lfsr_next;

    tx_len_pattern_gen_pattern_word_gen #(
        .OB (OB)
    ) u_word_gen (
        .mode      (mode_q),
        .idx       (idx_q),
        .lfsr      (lfsr_q),
        .word      (gen_word),
        .idx_next  (gen_idx_next),
        .lfsr_next (gen_lfsr_next)
    );

    // Next output word: in S_CMD the byte count is the length arriving now,
    // in S_SEND it is the count of bytes not yet loaded into the output.
    logic [31:0]     load_rem;
    logic [31:0]     rem_after;
    logic [OB-1:0]   load_keep;
    logic [8*OB-1:0] load_data;
    logic            load_last;

    always_comb begin
        load_rem  = (state_q == S_CMD) ? {i_tdata, len_lo_q} : remaining_q;
        load_keep = '0;
        load_data = '0;
        for (int i = 0; i < OB; i++) begin
            if (load_rem > 32'(i)) begin
                load_keep[i]       = 1'b1;
                load_data[8*i +: 8] = gen_word[8*i +: 8];
            end
        end
        load_last = (load_rem <= 32'(OB));
        rem_after = load_last ? 32'd0 : load_rem - 32'(OB);
    end

    always_comb begin
        // NOTE: every _d starts from its _q, so no path leaves a variable
        // unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        len_lo_d    = len_lo_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        o_tvalid_d  = o_tvalid_q;
        o_tdata_d   = o_tdata_q;
        o_tkeep_d   = o_tkeep_q;
        o_tlast_d   = o_tlast_q;
`ifdef TX_LEN_GEN_CMD_TIMEOUT_EN
        tmo_d       = '0;
`endif

        unique case (state_q)
            S_CMD: begin
                if (i_tvalid) begin
                    unique case (cnt_q)
                        3'd0: mode_d          = i_tdata[1:0];
                        3'd1: len_lo_d[7:0]   = i_tdata;
                        3'd2: len_lo_d[15:8]  = i_tdata;
                        3'd3: len_lo_d[23:16] = i_tdata;
                        default: ;
                    endcase
                    if (cnt_q == CMD_LAST) begin
                        cnt_d = '0;
                        // A zero length completes the command with no output.
                        if (load_rem != 32'd0) begin
                            state_d     = S_SEND;
                            o_tvalid_d  = 1'b1;
                            o_tdata_d   = load_data;
                            o_tkeep_d   = load_keep;
                            o_tlast_d   = load_last;
                            remaining_d = rem_after;
                            idx_d       = gen_idx_next;
                            lfsr_d      = gen_lfsr_next;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
`ifdef TX_LEN_GEN_CMD_TIMEOUT_EN
                else if (cnt_q != 3'd0) begin
                    // Idle with a partial command: discard it on expiry.
                    if (tmo_q == TMO_LAST) begin
                        cnt_d = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
`endif
            end

            S_SEND: begin
                if (o_tready && o_tvalid_q) begin
                    if (o_tlast_q) begin
                        state_d     = S_CMD;
                        o_tvalid_d  = 1'b0;
                        o_tdata_d   = '0;
                        o_tkeep_d   = '0;
                        o_tlast_d   = 1'b0;
                        remaining_d = '0;
                        idx_d       = '0;
                        lfsr_d      = LFSR_SEED;
                    end else begin
                        o_tdata_d   = load_data;
                        o_tkeep_d   = load_keep;
                        o_tlast_d   = load_last;
                        remaining_d = rem_after;
                        idx_d       = gen_idx_next;
                        lfsr_d      = gen_lfsr_next;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // from pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CMD;
            cnt_q       <= '0;
            mode_q      <= MODE_INC;
            len_lo_q    <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            o_tvalid_q  <= 1'b0;
            o_tdata_q   <= '0;
            o_tkeep_q   <= '0;
            o_tlast_q   <= 1'b0;
`ifdef TX_LEN_GEN_CMD_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            len_lo_q    <= len_lo_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            o_tvalid_q  <= o_tvalid_d;
            o_tdata_q   <= o_tdata_d;
            o_tkeep_q   <= o_tkeep_d;
            o_tlast_q   <= o_tlast_d;
`ifdef TX_LEN_GEN_CMD_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign i_tready = (state_q == S_CMD);
    assign busy     = (state_q == S_SEND);
    assign o_tvalid = o_tvalid_q;
    assign o_tdata  = o_tdata_q;
    assign o_tkeep  = o_tkeep_q;
    assign o_tlast  = o_tlast_q;

endmodule

// File: tb/tb_tx_len_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_tx_len_pattern_gen
//   Directed and randomised stimulus for tx_len_pattern_gen (OW_EW=2, 32-bit
//   output). Expected words come from a byte-list model of the pattern rules,
//   packed into 4-byte words. Honours TX_LEN_GEN_CMD_TIMEOUT_EN when defined.
// -----------------------------------------------------------------------------
module tb_tx_len_pattern_gen;

    localparam int OB      = 4;
    localparam int TMO     = 40;
    localparam int BUDGET  = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tready;
    logic        i_tvalid;
    logic [7:0]  i_tdata;
    logic        o_tready;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tlast;
    logic        busy;

    tx_len_pattern_gen #(
        .OW_EW          (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_tready (i_tready),
        .i_tvalid (i_tvalid),
        .i_tdata  (i_tdata),
        .o_tready (o_tready),
        .o_tvalid (o_tvalid),
        .o_tdata  (o_tdata),
        .o_tkeep  (o_tkeep),
        .o_tlast  (o_tlast),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte stream from the pattern rules, then packed OB bytes per word.
    task automatic build_model(input int mode, input int len);
        logic [7:0] bytes[$];
        int s = 1;
        exp_q.delete();
        for (int n = 0; n < len; n++) begin
            if (mode == 1) begin
                bytes.push_back(8'hFF);
            end else if (mode == 2) begin
                bytes.push_back(8'(s));
                s = ((s << 1) | (((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1)) & 255;
            end else begin
                bytes.push_back(8'(n % 256));
            end
        end
        for (int w = 0; w * OB < len; w++) begin
            word_t wd;
            wd.data = '0;
            wd.keep = '0;
            for (int i = 0; i < OB; i++) begin
                if (w * OB + i < len) begin
                    wd.data = wd.data | (32'(bytes[w * OB + i]) << (8 * i));
                    wd.keep[i] = 1'b1;
                end
            end
            wd.last = (w * OB + OB >= len);
            exp_q.push_back(wd);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_tdata  = b;
        i_tvalid = 1'b1;
        @(posedge clk); #1;
        i_tvalid = 1'b0;
    endtask

    task automatic send_cmd(input int mode, input int unsigned len);
        logic [7:0] b[5];
        b[0] = 8'(mode);
        b[1] = len[7:0];
        b[2] = len[15:8];
        b[3] = len[23:16];
        b[4] = len[31:24];
        for (int i = 0; i < 5; i++) begin
            i_tdata  = b[i];
            i_tvalid = 1'b1;
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0;
    endtask

    // Collects words until tlast (or max_words when nonzero), comparing each
    // handshake against exp_q and checking that stalled outputs hold.
    task automatic collect(input string tag, input bit rnd, input int max_words,
                           output int words, output int kbytes, output int lasts,
                           output int cycles);
        bit          done = 0;
        bit          stalled = 0;
        logic [31:0] hd;
        logic [3:0]  hk;
        logic        hl;
        words = 0; kbytes = 0; lasts = 0; cycles = 0;
        while (!done) begin
            o_tready = rnd ? 1'($urandom % 2) : 1'b1;
            if (stalled) begin
                check({tag, "_hold_valid"}, o_tvalid, 1);
                check({tag, "_hold_data"},  o_tdata,  hd);
                check({tag, "_hold_keep"},  o_tkeep,  hk);
                check({tag, "_hold_last"},  o_tlast,  hl);
            end
            if (o_tvalid && o_tready) begin
                if (words < exp_q.size()) begin
                    check({tag, "_data"}, o_tdata, exp_q[words].data);
                    check({tag, "_keep"}, o_tkeep, exp_q[words].keep);
                    check({tag, "_last"}, o_tlast, exp_q[words].last);
                end else begin
                    check({tag, "_extra_word"}, 64'(words), 64'(exp_q.size() - 1));
                end
                check({tag, "_busy"},     busy,     1);
                check({tag, "_i_tready"}, i_tready, 0);
                kbytes += $countones(o_tkeep);
                lasts  += int'(o_tlast);
                words++;
                if (o_tlast || words == max_words) done = 1;
            end
            stalled = o_tvalid && !o_tready;
            hd = o_tdata; hk = o_tkeep; hl = o_tlast;
            @(posedge clk); #1;
            cycles++;
            if (!done && cycles >= BUDGET) begin
                check({tag, "_burst_timeout"}, 64'(cycles), 64'(BUDGET - 1));
                done = 1;
            end
        end
        o_tready = 1'b0;
    endtask

    task automatic post_burst(input string tag);
        check({tag, "_end_valid"},  o_tvalid, 0);
        check({tag, "_end_busy"},   busy,     0);
        check({tag, "_end_tready"}, i_tready, 1);
    endtask

    initial begin
        int w, kb, nl, cyc;
        bit seen_valid;
        bit seen_notready;

        rst = 1'b1; i_tvalid = 1'b0; i_tdata = '0; o_tready = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_i_tready", i_tready, 1);
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tdata",  o_tdata,  0);
        check("rst_o_tkeep",  o_tkeep,  0);
        check("rst_o_tlast",  o_tlast,  0);
        check("rst_busy",     busy,     0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Incrementing, len=10: three words, final keep 3, no bubbles.
        build_model(0, 10);
        send_cmd(0, 10);
        check("t1_first_valid", o_tvalid, 1);
        collect("t1", 0, 0, w, kb, nl, cyc);
        check("t1_words",  w,   3);
        check("t1_cycles", cyc, 3);
        post_burst("t1");

        // Zero length: no output, then a normal command.
        send_cmd(0, 0);
        seen_valid = 0; seen_notready = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_tvalid)  seen_valid = 1;
            if (!i_tready) seen_notready = 1;
            @(posedge clk); #1;
        end
        check("t2_no_valid",     seen_valid,    0);
        check("t2_ready_stays",  seen_notready, 0);
        build_model(0, 4);
        send_cmd(0, 4);
        check("t2_first_valid", o_tvalid, 1);
        collect("t2", 0, 0, w, kb, nl, cyc);
        check("t2_words", w, 1);
        post_burst("t2");

        // LFSR, len=5.
        build_model(2, 5);
        send_cmd(2, 5);
        collect("t3", 0, 0, w, kb, nl, cyc);
        check("t3_words", w, 2);
        post_burst("t3");

        // Long burst with random backpressure.
        build_model(0, 1000);
        send_cmd(0, 1000);
        collect("t4", 1, 0, w, kb, nl, cyc);
        check("t4_words",  w,  250);
        check("t4_kbytes", kb, 1000);
        check("t4_lasts",  nl, 1);
        post_burst("t4");

        // Random modes and lengths, random backpressure.
        for (int k = 0; k < 4; k++) begin
            int md;
            int ln;
            md = int'($urandom % 4);
            ln = int'($urandom_range(1, 37));
            build_model(md, ln);
            send_cmd(md, ln);
            collect("rnd", 1, 0, w, kb, nl, cyc);
            check("rnd_kbytes", kb, ln);
            check("rnd_lasts",  nl, 1);
            post_burst("rnd");
        end

        // Reset in the middle of a burst.
        build_model(0, 100);
        send_cmd(0, 100);
        collect("t5", 0, 2, w, kb, nl, cyc);
        check("t5_words_before_rst", w, 2);
        rst = 1'b1;
        #1;
        check("t5_rst_valid",  o_tvalid, 0);
        check("t5_rst_last",   o_tlast,  0);
        check("t5_rst_keep",   o_tkeep,  0);
        check("t5_rst_data",   o_tdata,  0);
        check("t5_rst_busy",   busy,     0);
        check("t5_rst_tready", i_tready, 1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        build_model(0, 4);
        send_cmd(0, 4);
        collect("t5b", 0, 0, w, kb, nl, cyc);
        check("t5b_words", w, 1);
        post_burst("t5b");

        // Partial command followed by a long idle gap.
        send_byte(8'h02);
        send_byte(8'h01);
        repeat (TMO + 1) @(posedge clk);
        #1;
        send_cmd(0, 4);
        check("t6_first_valid", o_tvalid, 1);
`ifdef TX_LEN_GEN_CMD_TIMEOUT_EN
        build_model(0, 4);
        collect("t6", 0, 0, w, kb, nl, cyc);
        check("t6_words", w, 1);
        post_burst("t6");
`else
        // Misframed as mode 2 with a large length: first word is LFSR data.
        build_model(2, 8);
        collect("t6", 0, 1, w, kb, nl, cyc);
        check("t6_words", w, 1);
        check("t6_still_busy", busy, 1);
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_idle", i_tready, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
